// File: rtl/dm_loader_pkg.sv
// dm_loader shared definitions: DM geometry and loader FSM encoding.
// Optional checksum phase is enabled by DM_LOADER_CHECKSUM_EN.
package dm_loader_pkg;

    localparam int DM_ADDR_W = 6;
    localparam int DM_DATA_W = 32;
    localparam int BPW       = DM_DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
`ifdef DM_LOADER_CHECKSUM_EN
        ,
        S_CHK
`endif
    } state_t;

endpackage

// File: rtl/dm_loader_if.sv
// dm_loader bus bundle: inbound byte stream and DM write port.
// slave = loader side, master = host/memory side.
interface dm_loader_if
    import dm_loader_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dm_loader_asm.sv
// dm_loader byte-to-word assembler, little-endian byte order.
// word_next already contains the byte being taken this cycle.
module dm_loader_asm
    import dm_loader_pkg::*;
#(
    parameter int DATA_W = DM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              take,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word_next,
    output logic              word_full
);
    localparam int NB = DATA_W / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [IW-1:0]     bidx_q, bidx_d;
    logic [DATA_W-1:0] word_q, word_d;

    // insert the accepted byte at its lane and advance the byte index
    always_comb begin
        word_d    = word_q;
        bidx_d    = bidx_q;
        word_full = take && (bidx_q == IW'(NB - 1));
        if (take) begin
            word_d[8*bidx_q +: 8] = byte_in;
            bidx_d = word_full ? '0 : bidx_q + IW'(1);
        end
        word_next = word_d;
        if (clr) begin
            bidx_d = '0;
        end
    end

    // assembly register and byte index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bidx_q <= '0;
            word_q <= '0;
        end else begin
            bidx_q <= bidx_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/dm_loader.sv
// dm_loader: streams bytes into consecutive DM words, holding the CPU.
// Define DM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte.
module dm_loader
    import dm_loader_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    dm_loader_if.slave        bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   widx_q, widx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              asm_clr, asm_take, word_full;
    logic [DATA_W-1:0] word_next;
`ifdef DM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign bus.byte_ready = (state_q == S_RECV)
`ifdef DM_LOADER_CHECKSUM_EN
                         || (state_q == S_CHK)
`endif
                         ;
    assign asm_take = bus.byte_valid && (state_q == S_RECV) && !abort;

    dm_loader_asm #(.DATA_W(DATA_W)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (asm_clr),
        .take      (asm_take),
        .byte_in   (bus.byte_data),
        .word_next (word_next),
        .word_full (word_full)
    );

    // next-state, address counter and registered DM write port
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        asm_clr = 1'b0;
`ifdef DM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    base_d  = base_addr;
                    cnt_d   = word_count;
                    widx_d  = '0;
                    err_d   = 1'b0;
                    asm_clr = 1'b1;
`ifdef DM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = (word_count == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
`ifdef DM_LOADER_CHECKSUM_EN
                    if (asm_take) csum_d = csum_q ^ bus.byte_data;
`endif
                    if (word_full) begin
                        we_d    = 1'b1;
                        addr_d  = base_q + widx_q[ADDR_W-1:0];
                        wdata_d = word_next;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                widx_d = widx_q + (ADDR_W+1)'(1);
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (widx_q == cnt_q - (ADDR_W+1)'(1)) begin
`ifdef DM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_RECV;
                end
            end
`ifdef DM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.byte_valid) begin
                    if (bus.byte_data != csum_q) err_d = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (abort) err_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // loader state and DM port registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            widx_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
`ifdef DM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_hold      = (state_q != S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
endmodule
